gf2_poly_divider: RTL and testbench
===================================

# gf2_poly_divider

Sequential polynomial long-division unit over GF(2) for the SubBytes S-box datapath. It divides an 8-bit dividend polynomial by an 8-bit divisor polynomial and returns the quotient, the remainder and the remainder degree. It is the quotient/remainder step feeding the extended-Euclid inverse in the S-box. Each operation takes one start pulse and a fixed 8-step iteration.

## Interface
- No parameters; the operand width is fixed at 8 bits.
- clk  in  1  Single clock; all registers update on the rising edge.
- rst_n  in  1  Reset, asynchronous and active-low.
- start  in  1  Single-cycle request. Sampled only while idle (busy=0).
- in1  in  8  Dividend polynomial a(x); bit i is the coefficient of x^i. Sampled on the start edge.
- in2  in  8  Divisor polynomial b(x). Sampled on the start edge.
- busy  out  1  High while a division is in progress.
- done  out  1  One-cycle pulse when the results are valid.
- out1  out  8  Quotient q(x). Registered; held until the next done.
- out2  out  8  Remainder r(x). Registered; held until the next done.
- rem_deg  out  4  Index of the leading one of out2, range 0..7. Equals 4'hF when out2=0.
- div_zero  out  1  Set with done when in2 was 0. Held until the next done.

## Operation
- Invariant: a = q·b XOR r (carry-less product), with deg(r) < deg(b).
- Leading-one detector: for a 15-bit vector, returns the highest set bit index (0..14). Returns 4'hF for zero. Example: all-ones returns 4'b1110. The divisor degree d and rem_deg use it, zero-extended.
- On the start edge while idle:
  - Working remainder R ← in1, B ← in2, Q ← 0, d ← degree of in2, step index i ← 7.
  - busy ← 1.
- Step i, one per clock, for i = 7 down to 0:
  - If d+i ≤ 7 and R[d+i]=1, then R ← R XOR (B<<i) and Q[i] ← 1.
  - Otherwise R and Q are unchanged.
- After step 0: out1 ← Q, out2 ← R, rem_deg ← leading-one(R), div_zero ← 0, done ← 1, busy ← 0.
- Divisor zero (in2=0): no steps are evaluated, but the 8-step timing is kept. Results: out1=0, out2=in1, div_zero=1.
- Dividend degree below divisor degree: out1=0, out2=in1.
- start asserted while busy is ignored; no queuing.
- Changes on in1/in2 after the start edge do not affect the operation in flight.

## Timing
- Reset (asynchronous, rst_n=0): busy=0, done=0, out1=0, out2=0, rem_deg=4'hF, div_zero=0. Internal step state returns to idle.
- Start sampled at edge k → busy visible after edge k.
- Steps 7..0 occur on edges k+1..k+8. done=1 and the results are visible after edge k+8. done clears after edge k+9.
- Latency is fixed at 8 cycles from the start edge to done, for all operands including in2=0.
- start at edge k+8 (the done edge) is ignored; start at edge k+9 or later is accepted. Back-to-back throughput is one result per 9 cycles.
- Reset mid-operation aborts immediately with the reset values. No done is produced for the aborted operation.
- Outputs are glitch-free registers; rem_deg is derived from the registered out2.

## Test plan
- in1=0x05, in2=0x03, start → done after 8 cycles; out1=0x03, out2=0x00, rem_deg=4'hF, div_zero=0.
- in1=0xFF, in2=0x03 → out1=0x55, out2=0x00. Then in1=0x01, in2=0x02 → out1=0x00, out2=0x01, rem_deg=0.
- in1=0x78, in2=0xB6 (dividend degree < divisor degree) → out1=0x00, out2=0x78, rem_deg=6. Repeat 100 times back-to-back; results are identical every time.
- in1=0xFF, in2=0x00 → done at the same 8-cycle latency; div_zero=1, out1=0x00, out2=0xFF, rem_deg=7.
- Pulse start again at cycles 3 and 8 after the first start → both ignored; exactly one done occurs and busy stays high throughout.
- Drop rst_n at cycle 4 of a division → all outputs take their reset values immediately and no done pulse occurs. After release, a new start completes normally.
- Random sweep of 1000 operand pairs with in2≠0 → carry-less check a = q·b XOR r, and leading-one(r) < leading-one(b).

Source files
------------

// File: rtl/gf2_poly_divider_if.sv
// Request/result bundle for the GF(2) polynomial divider.
// The master drives the operands and start; the slave returns status and results.
interface gf2_poly_divider_if;
  logic       start;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       busy;
  logic       done;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [3:0] rem_deg;
  logic       div_zero;

  modport master (output start, in1, in2,
                  input  busy, done, out1, out2, rem_deg, div_zero);
  modport slave  (input  start, in1, in2,
                  output busy, done, out1, out2, rem_deg, div_zero);
endinterface

// File: rtl/gf2_poly_divider.sv
// Sequential GF(2) polynomial long division (8-bit operands), one quotient bit per clock
// from x^7 down to x^0; fixed 8-cycle latency from start to done.
module gf2_poly_divider (
  input  logic              clk,
  input  logic              rst_n,
  gf2_poly_divider_if.slave bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0] state;
  logic [7:0] rem_q;
  logic [7:0] div_q;
  logic [7:0] quo_q;
  logic [3:0] deg_q;
  logic [2:0] step_q;
  logic [7:0] out1_q;
  logic [7:0] out2_q;
  logic       done_q;
  logic       div_zero_q;

  logic [7:0] rem_next;
  logic [7:0] quo_next;
  logic [4:0] pos;

  function automatic logic [3:0] lead_one(input logic [14:0] v);
    lead_one = '1;
    for (int unsigned k = 0; k < 15; k++)
      if (v[k]) lead_one = k[3:0];
  endfunction

  // A zero divisor has degree 4'hF, so pos never falls in 0..7 and no step fires.
  always_comb begin
    rem_next = rem_q;
    quo_next = quo_q;
    pos      = {1'b0, deg_q} + {2'b00, step_q};
    if (pos <= 5'd7 && rem_q[pos[2:0]]) begin
      rem_next         = rem_q ^ (div_q << step_q);
      quo_next[step_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rem_q      <= '0;
      div_q      <= '0;
      quo_q      <= '0;
      deg_q      <= '1;
      step_q     <= '0;
      out1_q     <= '0;
      out2_q     <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            rem_q  <= bus.in1;
            div_q  <= bus.in2;
            quo_q  <= '0;
            deg_q  <= lead_one({7'b0, bus.in2});
            step_q <= 3'd7;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          rem_q  <= rem_next;
          quo_q  <= quo_next;
          step_q <= step_q - 3'd1;
          if (step_q == 3'd0) begin
            state      <= S_IDLE;
            out1_q     <= quo_next;
            out2_q     <= rem_next;
            div_zero_q <= (deg_q == 4'hF);
            done_q     <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_RUN);
  assign bus.done     = done_q;
  assign bus.out1     = out1_q;
  assign bus.out2     = out2_q;
  assign bus.rem_deg  = lead_one({7'b0, out2_q});
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_gf2_poly_divider.sv
// Bench for gf2_poly_divider: a cycle-level reference model checked every negedge,
// plus directed vectors with literal expectations and a carry-less identity sweep.
module tb_gf2_poly_divider;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  gf2_poly_divider_if bus();

  gf2_poly_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---- reference arithmetic, written as textbook long division ----
  function automatic int degree(input logic [15:0] v);
    degree = -1;
    for (int k = 0; k < 16; k++) if (v[k]) degree = k;
  endfunction

  function automatic logic [15:0] clmul(input logic [7:0] a, input logic [7:0] b);
    clmul = '0;
    for (int k = 0; k < 8; k++) if (b[k]) clmul = clmul ^ ({8'b0, a} << k);
  endfunction

  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r);
    logic [15:0] rr;
    int s;
    q  = '0;
    rr = {8'b0, a};
    if (b != 0) begin
      while (degree(rr) >= degree({8'b0, b})) begin
        s  = degree(rr) - degree({8'b0, b});
        rr = rr ^ ({8'b0, b} << s);
        q[s] = 1'b1;
      end
    end
    r = rr[7:0];
  endtask

  // ---- cycle model: accepts a start when idle, answers 8 edges later ----
  int         m_cnt   = 0;
  logic       m_busy  = 1'b0;
  logic       m_done  = 1'b0;
  logic [7:0] m_out1  = '0;
  logic [7:0] m_out2  = '0;
  logic       m_dz    = 1'b0;
  logic [7:0] m_pq, m_pr;
  logic       m_pdz;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] q, r;
    if (!rst_n) begin
      m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_out1 <= '0; m_out2 <= '0; m_dz <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_out1 <= m_pq; m_out2 <= m_pr; m_dz <= m_pdz;
        end
      end else if (bus.start) begin
        ref_div(bus.in1, bus.in2, q, r);
        m_pq <= q; m_pr <= r; m_pdz <= (bus.in2 == 0);
        m_cnt <= 8; m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int d;
    if (chk_en) begin
      d = degree({8'b0, m_out2});
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("out1", bus.out1, m_out1);
      chk("out2", bus.out2, m_out2);
      chk("rem_deg", bus.rem_deg, (d < 0) ? 4'hF : 4'(d));
      chk("div_zero", bus.div_zero, m_dz);
    end
  end

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic [3:0] rd, output logic dz);
    int cyc;
    bus.in1 = a; bus.in2 = b; bus.start = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.in1 = ~a; bus.in2 = ~b;
      end
      if (bus.done) break;
    end
    chk("latency", cyc - 1, 8);
    q = bus.out1; r = bus.out2; rd = bus.rem_deg; dz = bus.div_zero;
  endtask

  initial begin
    logic [7:0] q, r, a, b, q0, r0;
    logic [3:0] rd;
    logic dz;
    int dones, idle_cyc, dq, db;

    bus.start = 1'b0; bus.in1 = '0; bus.in2 = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst rem_deg", bus.rem_deg, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h05, 8'h03, q, r, rd, dz);
    chk("05/03 q", q, 8'h03); chk("05/03 r", r, 8'h00);
    chk("05/03 deg", rd, 4'hF); chk("05/03 dz", dz, 0);

    run_op(8'hFF, 8'h03, q, r, rd, dz);
    chk("FF/03 q", q, 8'h55); chk("FF/03 r", r, 8'h00);
    run_op(8'h01, 8'h02, q, r, rd, dz);
    chk("01/02 q", q, 8'h00); chk("01/02 r", r, 8'h01); chk("01/02 deg", rd, 4'h0);

    for (int n = 0; n < 100; n++) begin
      run_op(8'h78, 8'hB6, q, r, rd, dz);
      chk("78/B6 q", q, 8'h00); chk("78/B6 r", r, 8'h78); chk("78/B6 deg", rd, 4'h6);
    end

    run_op(8'hFF, 8'h00, q, r, rd, dz);
    chk("FF/00 dz", dz, 1); chk("FF/00 q", q, 8'h00);
    chk("FF/00 r", r, 8'hFF); chk("FF/00 deg", rd, 4'h7);

    // extra start pulses at cycles 3 and 8 must be dropped
    @(negedge clk);
    bus.in1 = 8'hFF; bus.in2 = 8'h03; bus.start = 1'b1;
    dones = 0; idle_cyc = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == 3 || cyc == 8);
      if (bus.done) dones++;
      if (cyc <= 8 && !bus.busy) idle_cyc++;
    end
    chk("ignored starts dones", dones, 1);
    chk("ignored starts busy gaps", idle_cyc, 0);
    chk("ignored starts q", bus.out1, 8'h55);

    // reset in the middle of a division
    bus.in1 = 8'hA7; bus.in2 = 8'h0B; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", bus.busy, 0); chk("abort done", bus.done, 0);
    chk("abort out1", bus.out1, 8'h00); chk("abort out2", bus.out2, 8'h00);
    chk("abort rem_deg", bus.rem_deg, 4'hF); chk("abort dz", bus.div_zero, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort no done", dones, 0);
    run_op(8'hA7, 8'h0B, q, r, rd, dz);
    ref_div(8'hA7, 8'h0B, q0, r0);
    chk("post-reset q", q, q0); chk("post-reset r", r, r0);

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op(a, b, q, r, rd, dz);
      chk("clmul identity", clmul(q, b) ^ {8'b0, r}, {8'b0, a});
      dq = degree({8'b0, r}); db = degree({8'b0, b});
      chk("rem degree bound", (dq < db) ? 1 : 0, 1);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
